serial_addsub: RTL and testbench



---
 rtl/serial_addsub.sv | 102 ++++++++++
 tb/tb_serial_addsub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/subtract, LSB first, one full-adder slice.
// Subtract is x + ~y + 1: the operand inversion happens at load and the +1
// is the initial carry. c_out is the carry out for add and not-borrow for
// subtract, so it matches the combinational datapath bit for bit.
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] res;

    logic             sum_bit;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Full-adder slice on the current LSBs; the sum enters the result at the MSB
    always_comb begin
        sum_bit   = a[0] ^ b[0] ^ carry;
        carry_nxt = (a[0] & b[0]) | (a[0] & carry) | (b[0] & carry);
        res_nxt   = {sum_bit, res[WIDTH-1:1]};
    end

    // Control FSM and datapath; s/c_out only change on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            a     <= '0;
            b     <= '0;
            carry <= 1'b0;
            count <= '0;
            res   <= '0;
        end else begin
            case (state)
                IDLE, DONE_ST: begin
                    // DONE accepts start like IDLE so operations can run back to back
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        a     <= x;
                        b     <= y ^ {WIDTH{cntrl}};
                        carry <= cntrl;
                        count <= '0;
                        res   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a     <= a >> 1;
                    b     <= b >> 1;
                    carry <= carry_nxt;
                    res   <= res_nxt;
                    if (count == LAST) begin
                        // Hold count at its last value so it never wraps
                        state <= DONE_ST;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        s     <= res_nxt;
                        c_out <= carry_nxt;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: directed table, handshake/abort sequences,
// exhaustive WIDTH=4 sweep and random WIDTH=8 sweep against plain arithmetic.
module tb_serial_addsub;

    logic clk;
    logic rst_n;

    logic       start4, c4, busy4, done4, co4;
    logic [3:0] x4, y4, s4;
    logic       start8, c8, busy8, done8, co8;
    logic [7:0] x8, y8, s8;

    int checks   = 0;
    int failures = 0;

    serial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4), .cntrl(c4),
        .busy(busy4), .done(done4), .s(s4), .c_out(co4)
    );

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8), .cntrl(c8),
        .busy(busy8), .done(done8), .s(s8), .c_out(co8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       c;
        logic [3:0] es;
        logic       ec;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: {c_out, s} from plain unsigned arithmetic on w-bit operands
    function automatic logic [31:0] ref_op(input int w, input logic [31:0] x,
                                           input logic [31:0] y, input logic c);
        logic [31:0] mask;
        mask = (32'd1 << w) - 1;
        if (!c) return (x + y) & ((mask << 1) | 32'd1);
        return ((x - y) & mask) | ((x >= y) ? (32'd1 << w) : 32'd0);
    endfunction

    // One WIDTH=4 operation with full timing checks; optional start pulse while busy
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic c,
                       input logic [3:0] es, input logic ec, input bit glitch, input string tag);
        int bc;
        int early;
        @(negedge clk);
        x4 = x; y4 = y; c4 = c; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        x4 = ~x; y4 = ~y; c4 = ~c;
        bc = 0; early = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy4) bc++;
            if (done4) early++;
            if (glitch && i == 1) start4 = 1'b1;
            if (glitch && i == 2) start4 = 1'b0;
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        chk({tag, " busy_cycles"}, bc, 4);
        chk({tag, " early_done"}, early, 0);
        chk({tag, " done"}, done4, 1'b1);
        chk({tag, " busy_in_done"}, busy4, 1'b0);
        chk({tag, " s"}, s4, es);
        chk({tag, " c_out"}, co4, ec);
        @(negedge clk);
        chk({tag, " done_pulse_len"}, done4, 1'b0);
        chk({tag, " s_hold"}, s4, es);
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [31:0] e;
        int dn;
        e = ref_op(8, x, y, c);
        @(negedge clk);
        x8 = x; y8 = y; c8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        x8 = $urandom; y8 = $urandom;
        dn = 0;
        for (int i = 0; i < 7; i++) begin
            if (done8 || !busy8) dn++;
            @(negedge clk);
        end
        if (done8 || !busy8) dn++;
        chk("w8 run_phase", dn, 0);
        @(negedge clk);
        chk("w8 done", done8, 1'b1);
        chk("w8 result", {co8, s8}, e[8:0]);
    endtask

    vec_t tbl[10];
    logic [3:0] ox[21];
    logic [3:0] oy[21];
    logic       oc[21];

    initial begin
        logic [31:0] e;
        int dn;
        rst_n = 1'b0;
        start4 = 1'b0; x4 = '0; y4 = '0; c4 = 1'b0;
        start8 = 1'b0; x8 = '0; y8 = '0; c8 = 1'b0;

        tbl[0] = '{4'd7,  4'd3,  1'b1, 4'd4,  1'b1};
        tbl[1] = '{4'd3,  4'd7,  1'b1, 4'hC,  1'b0};
        tbl[2] = '{4'd0,  4'd0,  1'b1, 4'd0,  1'b1};
        tbl[3] = '{4'd9,  4'd8,  1'b0, 4'd1,  1'b1};
        tbl[4] = '{4'd15, 4'd1,  1'b0, 4'd0,  1'b1};
        tbl[5] = '{4'd5,  4'd5,  1'b0, 4'hA,  1'b0};
        tbl[6] = '{4'd15, 4'd15, 1'b1, 4'd0,  1'b1};
        tbl[7] = '{4'd0,  4'd1,  1'b1, 4'hF,  1'b0};
        tbl[8] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1};
        tbl[9] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0};

        #3;
        chk("reset busy", busy4, 1'b0);
        chk("reset done", done4, 1'b0);
        chk("reset s", s4, 4'd0);
        chk("reset c_out", co4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++)
            op4(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].es, tbl[i].ec, 1'b0, $sformatf("tbl%0d", i));

        // start pulsed while busy is ignored
        op4(4'd9, 4'd8, 1'b0, 4'd1, 1'b1, 1'b1, "glitch");
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done4 || busy4) dn++;
        end
        chk("glitch no_second_op", dn, 0);

        // Asynchronous reset mid-cycle while outputs are nonzero
        op4(4'd7, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0, "pre_reset");
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async s", s4, 4'd0);
        chk("async c_out", co4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort during RUN cycle 2
        op4(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, "pre_abort");
        @(negedge clk);
        x4 = 4'd6; y4 = 4'd2; c4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", busy4, 1'b0);
        chk("abort done", done4, 1'b0);
        chk("abort s", s4, 4'd0);
        chk("abort c_out", co4, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (done4 || busy4) dn++;
        end
        chk("abort no_done", dn, 0);
        op4(4'd3, 4'd7, 1'b1, 4'hC, 1'b0, 1'b0, "post_abort");

        // start held high, operands change every cycle
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            if (k > 0) begin
                chk($sformatf("b2b done k=%0d", k), done4, (k % 5 == 0));
                if (k % 5 == 0) begin
                    e = ref_op(4, ox[k-5], oy[k-5], oc[k-5]);
                    chk($sformatf("b2b result k=%0d", k), {co4, s4}, e[4:0]);
                end
            end
            if (k < 20) begin
                ox[k] = 4'($urandom); oy[k] = 4'($urandom); oc[k] = 1'($urandom);
                x4 = ox[k]; y4 = oy[k]; c4 = oc[k]; start4 = 1'b1;
            end else begin
                start4 = 1'b0;
            end
        end
        @(negedge clk);

        // Exhaustive WIDTH=4 sweep
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++) begin
                    e = ref_op(4, i, j, 1'(c));
                    op4(4'(i), 4'(j), 1'(c), e[3:0], e[4], 1'b0, $sformatf("sw %0d %0d %0d", i, j, c));
                end

        // Random WIDTH=8 sweep including extremes
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h00, 8'h01, 1'b1);
        op8(8'h80, 8'h80, 1'b1);
        for (int n = 0; n < 200; n++)
            op8(8'($urandom), 8'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
